// File: rtl/btn_conditioner.sv
// Push-button conditioner: synchronise, debounce, one-cycle press/auto-repeat
// triggers, and a switch snapshot that is held constant between triggers.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000,
  parameter int DATA_WIDTH      = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  btn,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  trigger,
  output logic                  auto_repeat,
  output logic                  pressed,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ?
                         DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_C = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
  localparam int CW    = $clog2(MAX_C + 1);

  // The sample that leaves IDLE/HELD already counts as the first one.
  localparam logic [CW-1:0] DB_LAST =
    CW'((DEBOUNCE_CYCLES >= 2) ? DEBOUNCE_CYCLES - 2 : 0);
  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);
  localparam bit DB_ONE = (DEBOUNCE_CYCLES == 1);
  localparam bit RPT_ON = (REPEAT_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS_DB,
    S_HELD,
    S_REPEAT,
    S_RELEASE_DB
  } state_t;

  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic trig_n, rpt_n;

  logic btn_m, btn_s;
  logic [DATA_WIDTH-1:0] data_m, data_s;

  always_ff @(posedge clock) begin
    if (reset) begin
      btn_m  <= 1'b0;
      btn_s  <= 1'b0;
      data_m <= '0;
      data_s <= '0;
    end else begin
      btn_m  <= btn;
      btn_s  <= btn_m;
      data_m <= data_in;
      data_s <= data_m;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    trig_n  = 1'b0;
    rpt_n   = 1'b0;
    unique case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (btn_s) begin
          if (DB_ONE) begin
            state_n = S_HELD;
            trig_n  = 1'b1;
          end else begin
            state_n = S_PRESS_DB;
          end
        end
      end
      S_PRESS_DB: begin
        if (!btn_s) begin
          state_n = S_IDLE;
        end else if (cnt == DB_LAST) begin
          state_n = S_HELD;
          trig_n  = 1'b1;
        end
      end
      S_HELD: begin
        if (!btn_s) begin
          state_n = DB_ONE ? S_IDLE : S_RELEASE_DB;
        end else if (RPT_ON && cnt == RD_LAST) begin
          state_n = S_REPEAT;
          trig_n  = 1'b1;
          rpt_n   = 1'b1;
        end
      end
      S_REPEAT: begin
        if (!btn_s) begin
          state_n = DB_ONE ? S_IDLE : S_RELEASE_DB;
        end else if (cnt == RP_LAST) begin
          cnt_n  = '0;
          trig_n = 1'b1;
          rpt_n  = 1'b1;
        end
      end
      S_RELEASE_DB: begin
        if (btn_s) begin
          state_n = S_HELD;
        end else if (cnt == DB_LAST) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
    if (state_n != state) cnt_n = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      trigger     <= 1'b0;
      auto_repeat <= 1'b0;
      data_out    <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      trigger     <= trig_n;
      auto_repeat <= rpt_n;
      if (trig_n) data_out <= data_s;
    end
  end

  assign pressed = (state == S_HELD) || (state == S_REPEAT) ||
                   (state == S_RELEASE_DB);

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: press, bounce, repeat, glitch, reset.
// Cycle k is the interval after the k-th rising edge following the press.
module tb_btn_conditioner;

  logic clock = 1'b0;
  logic reset;
  logic btn;
  logic [15:0] data_in;

  logic trig, rpt, prs;
  logic [15:0] dout;
  logic trig_nr, rpt_nr, prs_nr;
  logic [15:0] dout_nr;
  logic trig_d1, rpt_d1, prs_d1;
  logic [15:0] dout_d1;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(4), .REPEAT_EN(1), .REPEAT_DELAY(10),
    .REPEAT_PERIOD(3), .DATA_WIDTH(16)
  ) dut (
    .clock(clock), .reset(reset), .btn(btn), .data_in(data_in),
    .trigger(trig), .auto_repeat(rpt), .pressed(prs), .data_out(dout)
  );

  btn_conditioner #(
    .DEBOUNCE_CYCLES(4), .REPEAT_EN(0), .REPEAT_DELAY(10),
    .REPEAT_PERIOD(3), .DATA_WIDTH(16)
  ) dut_nr (
    .clock(clock), .reset(reset), .btn(btn), .data_in(data_in),
    .trigger(trig_nr), .auto_repeat(rpt_nr), .pressed(prs_nr),
    .data_out(dout_nr)
  );

  btn_conditioner #(
    .DEBOUNCE_CYCLES(1), .REPEAT_EN(1), .REPEAT_DELAY(10),
    .REPEAT_PERIOD(3), .DATA_WIDTH(16)
  ) dut_d1 (
    .clock(clock), .reset(reset), .btn(btn), .data_in(data_in),
    .trigger(trig_d1), .auto_repeat(rpt_d1), .pressed(prs_d1),
    .data_out(dout_d1)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    btn = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    btn = 1'b1;
    data_in = 16'hFFFF;
    tick();
    tick();
    tick();
    total++;
    if ({trig, rpt, prs} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags got=%b want=000", {trig, rpt, prs});
    end
    total++;
    if (dout !== 16'h0000) begin
      bad++;
      $display("FAIL reset_dout got=%h want=0000", dout);
    end
    total++;
    if ({trig_nr, prs_nr, trig_d1, prs_d1} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_others got=%b want=0000",
               {trig_nr, prs_nr, trig_d1, prs_d1});
    end
    btn = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_clean_press;
    logic et, ep;
    data_in = 16'h3A05;
    do_reset();
    btn = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      et = (k == 6);
      ep = (k >= 6 && k < 14);
      total++;
      if (trig !== et) begin
        bad++;
        $display("FAIL press_trig k=%0d got=%b want=%b", k, trig, et);
      end
      total++;
      if (rpt !== 1'b0) begin
        bad++;
        $display("FAIL press_rpt k=%0d got=%b want=0", k, rpt);
      end
      total++;
      if (prs !== ep) begin
        bad++;
        $display("FAIL press_prs k=%0d got=%b want=%b", k, prs, ep);
      end
      if (k >= 6) begin
        total++;
        if (dout !== 16'h3A05) begin
          bad++;
          $display("FAIL press_dout k=%0d got=%h want=3a05", k, dout);
        end
      end
      et = (k == 3);
      ep = (k >= 3 && k < 11);
      total++;
      if (trig_d1 !== et || prs_d1 !== ep) begin
        bad++;
        $display("FAIL d1_press k=%0d got=%b%b want=%b%b",
                 k, trig_d1, prs_d1, et, ep);
      end
      if (k == 8) btn = 1'b0;
    end
  endtask

  task automatic test_bounce;
    logic et, ep;
    data_in = 16'h0C0C;
    do_reset();
    btn = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      et = (k == 21);
      ep = (k >= 21);
      total++;
      if (trig !== et) begin
        bad++;
        $display("FAIL bounce_trig k=%0d got=%b want=%b", k, trig, et);
      end
      total++;
      if (prs !== ep) begin
        bad++;
        $display("FAIL bounce_prs k=%0d got=%b want=%b", k, prs, ep);
      end
      btn = (k >= 15) || (k % 3 != 2);
    end
    total++;
    if (dout !== 16'h0C0C) begin
      bad++;
      $display("FAIL bounce_dout got=%h want=0c0c", dout);
    end
  endtask

  task automatic test_auto_repeat;
    logic et, er, ep;
    logic [15:0] ed;
    data_in = 16'h00FF;
    do_reset();
    btn = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      er = (k == 16 || k == 19 || k == 22 || k == 25 ||
            k == 28 || k == 31);
      et = er || (k == 6);
      ep = (k >= 6 && k < 36);
      ed = (k < 6) ? 16'h0000 : (k < 16) ? 16'h00FF : 16'h1234;
      total++;
      if (trig !== et) begin
        bad++;
        $display("FAIL rep_trig k=%0d got=%b want=%b", k, trig, et);
      end
      total++;
      if (rpt !== er) begin
        bad++;
        $display("FAIL rep_flag k=%0d got=%b want=%b", k, rpt, er);
      end
      total++;
      if (prs !== ep) begin
        bad++;
        $display("FAIL rep_prs k=%0d got=%b want=%b", k, prs, ep);
      end
      total++;
      if (dout !== ed) begin
        bad++;
        $display("FAIL rep_dout k=%0d got=%h want=%h", k, dout, ed);
      end
      if (k == 12) data_in = 16'h1234;
      if (k == 30) btn = 1'b0;
    end
  endtask

  task automatic test_no_repeat;
    logic et, ep;
    data_in = 16'hBEEF;
    do_reset();
    btn = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      tick();
      et = (k == 6);
      ep = (k >= 6 && k < 46);
      total++;
      if (trig_nr !== et || rpt_nr !== 1'b0) begin
        bad++;
        $display("FAIL norep_trig k=%0d got=%b%b want=%b0",
                 k, trig_nr, rpt_nr, et);
      end
      total++;
      if (prs_nr !== ep) begin
        bad++;
        $display("FAIL norep_prs k=%0d got=%b want=%b", k, prs_nr, ep);
      end
      if (k == 40) btn = 1'b0;
    end
    total++;
    if (dout_nr !== 16'hBEEF) begin
      bad++;
      $display("FAIL norep_dout got=%h want=beef", dout_nr);
    end
  endtask

  task automatic test_release_glitch;
    logic et, er, ep;
    data_in = 16'h7777;
    do_reset();
    btn = 1'b1;
    for (int k = 1; k <= 28; k++) begin
      tick();
      er = (k == 23 || k == 26);
      et = er || (k == 6);
      ep = (k >= 6);
      total++;
      if (trig !== et || rpt !== er) begin
        bad++;
        $display("FAIL glitch_trig k=%0d got=%b%b want=%b%b",
                 k, trig, rpt, et, er);
      end
      total++;
      if (prs !== ep) begin
        bad++;
        $display("FAIL glitch_prs k=%0d got=%b want=%b", k, prs, ep);
      end
      if (k == 8) btn = 1'b0;
      if (k == 10) btn = 1'b1;
    end
  endtask

  task automatic test_reset_mid_hold;
    logic et, ep;
    logic [15:0] ed;
    data_in = 16'h5555;
    do_reset();
    btn = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      et = (k == 6 || k == 21);
      ep = (k >= 6 && k < 15) || (k >= 21);
      ed = ep ? 16'h5555 : 16'h0000;
      total++;
      if (trig !== et || rpt !== 1'b0) begin
        bad++;
        $display("FAIL rst_trig k=%0d got=%b%b want=%b0", k, trig, rpt, et);
      end
      total++;
      if (prs !== ep) begin
        bad++;
        $display("FAIL rst_prs k=%0d got=%b want=%b", k, prs, ep);
      end
      total++;
      if (dout !== ed) begin
        bad++;
        $display("FAIL rst_dout k=%0d got=%h want=%h", k, dout, ed);
      end
      if (k == 14) reset = 1'b1;
      if (k == 15) reset = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1;
    btn = 1'b0;
    data_in = 16'h0000;
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_no_repeat();
    test_release_glitch();
    test_reset_mid_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
